fxp_mult_pipe: RTL and testbench

//  Parametrised signed fixed-point multiplier for the datapath: A*B in Q(WIDTH-FRAC).FRAC,

---
 rtl/fxp_mult_pipe.sv | 100 ++++++++++
 tb/tb_fxp_mult_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mult_pipe.sv
// rtl/fxp_mult_pipe.sv - pipelined signed fixed-point multiplier with rounding, saturation and MAC
module fxp_mult_pipe #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int STAGES = 2,
    parameter int ROUND  = 1,
    parameter int SAT    = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic                    ACC,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic signed [WIDTH-1:0] C,
    output logic                    OVF,
    output logic                    OVF_STICKY,
    input  logic                    OVF_CLR
);

    localparam int PW = 2 * WIDTH;
    // Two guard bits keep rounding and accumulation free of internal overflow.
    localparam int SW = 2 * WIDTH + 2;
    localparam logic signed [SW-1:0] RND_C = (ROUND != 0) ? (SW'(1) << (FRAC - 1)) : SW'(0);
    localparam logic signed [SW-1:0] C_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] C_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                    adv;
    logic [PW-1:0]           a_ext;
    logic [PW-1:0]           b_ext;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    p_pipe   [1:STAGES-1];
    logic                    acc_pipe [1:STAGES-1];
    logic                    vld_pipe [1:STAGES-1];
    logic signed [SW-1:0]    p_ext;
    logic signed [SW-1:0]    q_val;
    logic signed [SW-1:0]    s_val;
    logic signed [SW-1:0]    c_ext;
    logic                    ovf_n;
    logic signed [WIDTH-1:0] c_n;

    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    assign prod  = a_ext * b_ext;

    always_comb begin
        p_ext = {{(SW-PW){p_pipe[STAGES-1][PW-1]}}, p_pipe[STAGES-1]};
        q_val = (p_ext + RND_C) >>> FRAC;
        c_ext = {{(SW-WIDTH){C[WIDTH-1]}}, C};
        s_val = q_val;
        if (acc_pipe[STAGES-1]) begin
            s_val = q_val + c_ext;
        end
        ovf_n = (s_val > C_MAX) || (s_val < C_MIN);
        c_n   = s_val[WIDTH-1:0];
        if ((SAT != 0) && ovf_n) begin
            c_n = s_val[SW-1] ? C_MIN[WIDTH-1:0] : C_MAX[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 1; i < STAGES; i++) begin
                p_pipe[i]   <= '0;
                acc_pipe[i] <= 1'b0;
                vld_pipe[i] <= 1'b0;
            end
            OUT_VALID  <= 1'b0;
            C          <= '0;
            OVF        <= 1'b0;
            OVF_STICKY <= 1'b0;
        end else begin
            OVF_STICKY <= (OVF_STICKY && !OVF_CLR) || (adv && vld_pipe[STAGES-1] && ovf_n);
            if (adv) begin
                p_pipe[1]   <= prod;
                acc_pipe[1] <= ACC;
                vld_pipe[1] <= IN_VALID;
                for (int i = 2; i < STAGES; i++) begin
                    p_pipe[i]   <= p_pipe[i-1];
                    acc_pipe[i] <= acc_pipe[i-1];
                    vld_pipe[i] <= vld_pipe[i-1];
                end
                OUT_VALID <= vld_pipe[STAGES-1];
                // A bubble reaching the output keeps C so a later ACC still sees the last result.
                if (vld_pipe[STAGES-1]) begin
                    C   <= c_n;
                    OVF <= ovf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb/tb_fxp_mult_pipe.sv - randomized and directed self-checking bench for fxp_mult_pipe
module tb_fxp_mult_pipe;

    localparam int N = 3;
    localparam int STG   [N] = '{2, 2, 4};
    localparam int RND_P [N] = '{1, 0, 1};
    localparam int SAT_P [N] = '{1, 0, 1};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        acc = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready  [N];
    logic        out_valid [N];
    logic        ovf       [N];
    logic        sticky    [N];
    logic [15:0] c         [N];

    int checks = 0;
    int failures = 0;

    logic [16:0] fifo [N][64];
    int          wr [N] = '{0, 0, 0};
    int          rd [N] = '{0, 0, 0};
    logic [15:0] prev [N];
    logic        stall_d [N];
    logic [15:0] c_d [N];
    logic        ovf_d [N];
    logic        st_m [N];
    logic        clr_d;
    int          lat [N];
    logic [15:0] c_at [N];

    always #5 CLK = ~CLK;

    for (genvar k = 0; k < N; k++) begin : g_dut
        fxp_mult_pipe #(
            .WIDTH(16), .FRAC(8), .STAGES(STG[k]), .ROUND(RND_P[k]), .SAT(SAT_P[k])
        ) u_dut (
            .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready[k]),
            .A(a), .B(b), .ACC(acc), .OUT_VALID(out_valid[k]), .OUT_READY(out_ready),
            .C(c[k]), .OVF(ovf[k]), .OVF_STICKY(sticky[k]), .OVF_CLR(ovf_clr)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Q8.8 result from plain integer arithmetic: {ovf, c}.
    function automatic logic [16:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic ac, input logic [15:0] pc,
                                            input int rnd, input int sat);
        longint p, q, s;
        logic [63:0] su;
        logic [15:0] r;
        logic        o;
        p = longint'($signed(x)) * longint'($signed(y));
        q = (rnd != 0) ? ((p + 128) >>> 8) : (p >>> 8);
        s = q + (ac ? longint'($signed(pc)) : 64'sd0);
        o = (s > 32767) || (s < -32768);
        su = s;
        r = su[15:0];
        if (sat != 0 && s > 32767) r = 16'h7FFF;
        if (sat != 0 && s < -32768) r = 16'h8000;
        return {o, r};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send1(input logic [15:0] x, input logic [15:0] y, input logic ac);
        in_valid = 1'b1; a = x; b = y; acc = ac;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic chk_out(input int k, input logic [15:0] ec, input logic eo, input string tag);
        check_eq({tag, "_v"}, 32'(out_valid[k]), 32'd1);
        check_eq({tag, "_c"}, 32'(c[k]), 32'(ec));
        check_eq({tag, "_ovf"}, 32'(ovf[k]), 32'(eo));
    endtask

    // Transaction-level scoreboard sampled on the falling edge.
    initial begin
        logic [16:0] e;
        logic        new_res;
        logic        exp_st;
        forever begin
            @(negedge CLK);
            for (int k = 0; k < N; k++) begin
                if (RST) begin
                    wr[k] = 0; rd[k] = 0; prev[k] = '0; stall_d[k] = 1'b0; st_m[k] = 1'b0;
                end else begin
                    check_eq($sformatf("in_ready%0d", k), 32'(in_ready[k]),
                             32'(!(out_valid[k] && !out_ready)));
                    if (stall_d[k]) begin
                        check_eq($sformatf("hold_v%0d", k), 32'(out_valid[k]), 32'd1);
                        check_eq($sformatf("hold_c%0d", k), 32'(c[k]), 32'(c_d[k]));
                        check_eq($sformatf("hold_ovf%0d", k), 32'(ovf[k]), 32'(ovf_d[k]));
                    end
                    new_res = out_valid[k] && !stall_d[k];
                    e = fifo[k][rd[k] % 64];
                    exp_st = (st_m[k] && !clr_d) || (new_res && wr[k] != rd[k] && e[16]);
                    check_eq($sformatf("sticky%0d", k), 32'(sticky[k]), 32'(exp_st));
                    st_m[k] = exp_st;
                    if (out_valid[k] && out_ready) begin
                        check_eq($sformatf("pending%0d", k), 32'(wr[k] != rd[k]), 32'd1);
                        if (wr[k] != rd[k]) begin
                            check_eq($sformatf("c%0d", k), 32'(c[k]), 32'(e[15:0]));
                            check_eq($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(e[16]));
                            rd[k]++;
                        end
                    end
                    if (in_valid && in_ready[k]) begin
                        e = ref_mul(a, b, acc, prev[k], RND_P[k], SAT_P[k]);
                        fifo[k][wr[k] % 64] = e;
                        wr[k]++;
                        prev[k] = e[15:0];
                    end
                    stall_d[k] = out_valid[k] && !out_ready;
                    c_d[k] = c[k];
                    ovf_d[k] = ovf[k];
                end
            end
            clr_d = RST ? 1'b0 : ovf_clr;
        end
    end

    initial begin
        RST = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("rst_v%0d", k), 32'(out_valid[k]), 32'd0);
            check_eq($sformatf("rst_c%0d", k), 32'(c[k]), 32'd0);
            check_eq($sformatf("rst_st%0d", k), 32'(sticky[k]), 32'd0);
        end
        RST = 1'b0;
        out_ready = 1'b1;
        tick();

        send1(16'h0180, 16'h0200, 1'b0);
        chk_out(0, 16'h0300, 1'b0, "basic");
        check_eq("basic_lat4_early", 32'(out_valid[2]), 32'd0);
        repeat (2) tick();
        chk_out(2, 16'h0300, 1'b0, "basic_s4");

        send1(16'h0001, 16'h0080, 1'b0);
        chk_out(0, 16'h0001, 1'b0, "rnd_up");
        chk_out(1, 16'h0000, 1'b0, "trunc_up");
        send1(16'hFFFF, 16'h0080, 1'b0);
        chk_out(0, 16'h0000, 1'b0, "rnd_neg");
        chk_out(1, 16'hFFFF, 1'b0, "trunc_neg");

        send1(16'h7FFF, 16'h7FFF, 1'b0);
        chk_out(0, 16'h7FFF, 1'b1, "sat_pos");
        check_eq("sat_sticky", 32'(sticky[0]), 32'd1);
        chk_out(1, 16'hFF00, 1'b1, "wrap_pos");
        send1(16'h8000, 16'h8000, 1'b0);
        chk_out(0, 16'h7FFF, 1'b1, "sat_negneg");

        send1(16'h0100, 16'h0100, 1'b0);
        chk_out(0, 16'h0100, 1'b0, "mac0");
        send1(16'h0200, 16'h0100, 1'b1);
        chk_out(0, 16'h0300, 1'b0, "mac1");
        send1(16'h7F00, 16'h0100, 1'b1);
        chk_out(0, 16'h7FFF, 1'b1, "mac2");
        repeat (3) tick();

        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            a         = 16'($urandom >> (($urandom % 2) * 8));
            b         = 16'($urandom >> (($urandom % 2) * 8));
            acc       = 1'($urandom % 2);
            out_ready = 1'($urandom % 2);
            ovf_clr   = ($urandom % 8) == 0;
            tick();
        end
        in_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 20 && (wr[0] != rd[0] || wr[1] != rd[1] || wr[2] != rd[2]); n++) tick();
        for (int k = 0; k < N; k++) check_eq($sformatf("drain%0d", k), 32'(wr[k] - rd[k]), 32'd0);

        in_valid = 1'b1; a = 16'h7FFF; b = 16'h7FFF; acc = 1'b0;
        repeat (3) tick();
        in_valid = 1'b0;
        check_eq("pre_rst_sticky", 32'(sticky[0]), 32'd1);
        RST = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("mid_rst_v%0d", k), 32'(out_valid[k]), 32'd0);
            check_eq($sformatf("mid_rst_c%0d", k), 32'(c[k]), 32'd0);
            check_eq($sformatf("mid_rst_st%0d", k), 32'(sticky[k]), 32'd0);
        end
        tick();
        RST = 1'b0;
        tick();
        in_valid = 1'b1; a = 16'h0180; b = 16'h0200; acc = 1'b1;
        for (int k = 0; k < N; k++) begin lat[k] = 0; c_at[k] = '0; end
        for (int n = 1; n <= 10; n++) begin
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (lat[k] == 0 && out_valid[k]) begin lat[k] = n; c_at[k] = c[k]; end
            end
        end
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("lat%0d", k), 32'(lat[k]), 32'(STG[k]));
            check_eq($sformatf("lat_c%0d", k), 32'(c_at[k]), 32'h0300);
        end

        in_valid = 1'b1; a = 16'h7FFF; b = 16'h7FFF; acc = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("st_set2", 32'(sticky[2]), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("clr_vs_set", 32'(sticky[0]), 32'd1);
        check_eq("clr_only", 32'(sticky[2]), 32'd0);
        repeat (2) tick();
        check_eq("reset_after_clr", 32'(sticky[2]), 32'd1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
